// File: rtl/mmc3_irq_sched.sv
// MMC3-family scanline IRQ scheduler: synchronizes M2/A12, turns A12 edges into
// counter clock events (rev-B filter or Acclaim prescaler) and runs the IRQ counter.
module mmc3_irq_sched (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       cpu_m2,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_data,
  input  logic [3:0] reg_addr,
  input  logic       ppu_a12,
  input  logic       mode,
  output logic       irq
);

  logic       m2_s1_q, m2_s1_d;
  logic       m2_s2_q, m2_s2_d;
  logic       m2_s3_q, m2_s3_d;
  logic       a12_s1_q, a12_s1_d;
  logic       a12_s2_q, a12_s2_d;
  logic       a12_s3_q, a12_s3_d;

  logic       cap_rw_q, cap_rw_d;
  logic [3:0] cap_addr_q, cap_addr_d;
  logic [7:0] cap_data_q, cap_data_d;
  logic       wr_stb_q, wr_stb_d;

  logic       clk_evt_q, clk_evt_d;
  logic [1:0] low_cnt_q, low_cnt_d;
  logic [2:0] prescaler_q, prescaler_d;

  logic [7:0] counter_q, counter_d;
  logic [7:0] latch_q, latch_d;
  logic       reload_q, reload_d;
  logic       en_q, en_d;
  logic       irq_q, irq_d;

  logic       m2_fall, a12_rise, a12_fall;
  logic       wr_c000, wr_c001, wr_e000, wr_e001;
  logic [7:0] step_next;
  logic       irq_set;

  always_comb begin
    m2_s1_d  = cpu_m2;
    m2_s2_d  = m2_s1_q;
    m2_s3_d  = m2_s2_q;
    a12_s1_d = ppu_a12;
    a12_s2_d = a12_s1_q;
    a12_s3_d = a12_s2_q;
  end

  assign m2_fall  = m2_s3_q & ~m2_s2_q;
  assign a12_rise = a12_s2_q & ~a12_s3_q;
  assign a12_fall = a12_s3_q & ~a12_s2_q;

  // The bus is sampled throughout M2-high, so the values held at the falling
  // edge are the last ones the CPU drove while the cycle was still valid.
  always_comb begin
    cap_rw_d   = cap_rw_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    if (m2_s2_q) begin
      cap_rw_d   = cpu_rw;
      cap_addr_d = reg_addr;
      cap_data_d = cpu_data;
    end
    wr_stb_d = m2_fall & ~cap_rw_q & cap_addr_q[3];
  end

  always_comb begin
    wr_c000 = 1'b0;
    wr_c001 = 1'b0;
    wr_e000 = 1'b0;
    wr_e001 = 1'b0;
    if (wr_stb_q) begin
      case (cap_addr_q[2:0])
        3'b100:  wr_c000 = 1'b1;
        3'b101:  wr_c001 = 1'b1;
        3'b110:  wr_e000 = 1'b1;
        3'b111:  wr_e001 = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    low_cnt_d   = low_cnt_q;
    prescaler_d = prescaler_q;
    clk_evt_d   = 1'b0;
    if (!mode) begin
      if (a12_rise) begin
        clk_evt_d = (low_cnt_q == 2'd3);
        low_cnt_d = 2'd0;
      end else if (m2_fall && !a12_s2_q && (low_cnt_q != 2'd3)) begin
        low_cnt_d = low_cnt_q + 2'd1;
      end
    end else if (a12_fall) begin
      prescaler_d = prescaler_q + 3'd1;
      clk_evt_d   = (prescaler_q == 3'd7);
    end
    if (wr_c001) begin
      prescaler_d = 3'd0;
    end
  end

  // Same-clk priority: a reload write swallows a clock event, and $E000 wins
  // over a fresh IRQ; the step itself always sees the old latch and enable.
  always_comb begin
    step_next = ((counter_q == 8'd0) || reload_q) ? latch_q : (counter_q - 8'd1);
    counter_d = counter_q;
    reload_d  = reload_q;
    latch_d   = latch_q;
    en_d      = en_q;
    irq_d     = irq_q;
    irq_set   = 1'b0;
    if (wr_c001) begin
      counter_d = 8'd0;
      reload_d  = 1'b1;
    end else if (clk_evt_q) begin
      counter_d = step_next;
      reload_d  = 1'b0;
      irq_set   = (step_next == 8'd0) && en_q;
    end
    if (wr_c000) begin
      latch_d = cap_data_q;
    end
    if (wr_e000) begin
      en_d = 1'b0;
    end else if (wr_e001) begin
      en_d = 1'b1;
    end
    if (wr_e000) begin
      irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      m2_s1_q     <= 1'b0;
      m2_s2_q     <= 1'b0;
      m2_s3_q     <= 1'b0;
      a12_s1_q    <= 1'b0;
      a12_s2_q    <= 1'b0;
      a12_s3_q    <= 1'b0;
      cap_rw_q    <= 1'b0;
      cap_addr_q  <= 4'd0;
      cap_data_q  <= 8'd0;
      wr_stb_q    <= 1'b0;
      clk_evt_q   <= 1'b0;
      low_cnt_q   <= 2'd0;
      prescaler_q <= 3'd0;
      counter_q   <= 8'd0;
      latch_q     <= 8'd0;
      reload_q    <= 1'b0;
      en_q        <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      m2_s1_q     <= m2_s1_d;
      m2_s2_q     <= m2_s2_d;
      m2_s3_q     <= m2_s3_d;
      a12_s1_q    <= a12_s1_d;
      a12_s2_q    <= a12_s2_d;
      a12_s3_q    <= a12_s3_d;
      cap_rw_q    <= cap_rw_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      wr_stb_q    <= wr_stb_d;
      clk_evt_q   <= clk_evt_d;
      low_cnt_q   <= low_cnt_d;
      prescaler_q <= prescaler_d;
      counter_q   <= counter_d;
      latch_q     <= latch_d;
      reload_q    <= reload_d;
      en_q        <= en_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmc3_irq_sched.sv
// Self-checking bench for mmc3_irq_sched: a transaction-level model pushes the
// expected irq/counter/reload state per stimulus; each test pops and compares.
`timescale 1ns/1ps
module tb_mmc3_irq_sched;

  logic       clk = 1'b0;
  logic       map_rst = 1'b0;
  logic       cpu_m2 = 1'b0;
  logic       cpu_rw = 1'b1;
  logic [7:0] cpu_data = 8'd0;
  logic [3:0] reg_addr = 4'd0;
  logic       ppu_a12 = 1'b0;
  logic       mode = 1'b0;
  logic       irq;

  localparam logic [3:0] A_C000 = 4'b1100;
  localparam logic [3:0] A_C001 = 4'b1101;
  localparam logic [3:0] A_E000 = 4'b1110;
  localparam logic [3:0] A_E001 = 4'b1111;

  typedef struct packed {
    logic       irq_v;
    logic [7:0] cnt_v;
    logic       rl_v;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0] m_latch, m_cnt;
  logic       m_reload, m_en, m_irq, m_a12;
  logic [1:0] m_low;
  logic [2:0] m_pre;

  mmc3_irq_sched dut (
    .clk      (clk),
    .map_rst  (map_rst),
    .cpu_m2   (cpu_m2),
    .cpu_rw   (cpu_rw),
    .cpu_data (cpu_data),
    .reg_addr (reg_addr),
    .ppu_a12  (ppu_a12),
    .mode     (mode),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_latch = 8'd0; m_cnt = 8'd0; m_reload = 1'b0; m_en = 1'b0;
    m_irq = 1'b0; m_low = 2'd0; m_pre = 3'd0;
  endtask

  task automatic model_step();
    if (m_cnt == 8'd0 || m_reload) begin
      m_cnt = m_latch;
      m_reload = 1'b0;
    end else begin
      m_cnt = m_cnt - 8'd1;
    end
    if (m_cnt == 8'd0 && m_en) m_irq = 1'b1;
  endtask

  task automatic model_a12_rise();
    if (!mode) begin
      if (m_low == 2'd3) model_step();
      m_low = 2'd0;
    end
  endtask

  task automatic model_a12_fall();
    if (mode) begin
      m_pre = m_pre + 3'd1;
      if (m_pre == 3'd0) model_step();
    end
  endtask

  task automatic model_m2_fall();
    if (!mode && !m_a12 && m_low != 2'd3) m_low = m_low + 2'd1;
  endtask

  // Write effects are applied after any coincident event, which captures the
  // required same-clk priorities (old latch/enable used, reload and $E000 win).
  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    case (a)
      A_C000: m_latch = d;
      A_C001: begin m_cnt = 8'd0; m_reload = 1'b1; m_pre = 3'd0; end
      A_E000: begin m_en = 1'b0; m_irq = 1'b0; end
      A_E001: m_en = 1'b1;
      default: ;
    endcase
  endtask

  task automatic push_expect();
    exp_t e;
    e.irq_v = m_irq;
    e.cnt_v = m_cnt;
    e.rl_v  = m_reload;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    tick(6);
  endtask

  task automatic do_reset(input logic m);
    @(posedge clk); #1;
    mode = m;
    map_rst = 1'b1;
    ppu_a12 = 1'b0; cpu_m2 = 1'b0; cpu_rw = 1'b1;
    m_a12 = 1'b0;
    model_reset();
    tick(1);
    map_rst = 1'b0;
    tick(2);
  endtask

  // One CPU write cycle; with_rise lines the A12 rise up with the M2 fall so
  // the write strobe and the clock event land in the same clk.
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input bit with_rise);
    @(posedge clk); #1;
    cpu_rw = 1'b0; reg_addr = a; cpu_data = d; cpu_m2 = 1'b1;
    tick(10);
    cpu_m2 = 1'b0;
    if (with_rise) begin
      ppu_a12 = 1'b1;
      m_a12 = 1'b1;
      model_a12_rise();
    end else begin
      model_m2_fall();
    end
    model_write(a, d);
    tick(10);
    cpu_rw = 1'b1;
    push_expect();
  endtask

  task automatic m2_cycles(input int n);
    cpu_rw = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_m2 = 1'b1;
      tick(10);
      cpu_m2 = 1'b0;
      model_m2_fall();
      tick(9);
    end
  endtask

  task automatic a12_set(input logic v);
    @(posedge clk); #1;
    ppu_a12 = v;
    m_a12 = v;
    if (v) model_a12_rise();
    else model_a12_fall();
    push_expect();
  endtask

  task automatic test_reset();
    map_rst = 1'b0;
    #3 map_rst = 1'b1;
    #4;
    n_checks++;
    if (irq !== 1'b0 || dut.counter_q !== 8'd0 || dut.reload_q !== 1'b0 || dut.latch_q !== 8'd0)
      $display("[TB] FAIL reset_state: got irq=%0b cnt=%0d reload=%0b latch=%0d, want all 0",
               irq, dut.counter_q, dut.reload_q, dut.latch_q);
    else n_pass++;
    tick(2);
    map_rst = 1'b0;
    m_a12 = 1'b0;
    model_reset();
    tick(2);
  endtask

  task automatic test_basic_count();
    exp_t e;
    do_reset(1'b0);
    bus_write(A_C000, 8'd3, 1'b0); void'(sb_q.pop_front());
    bus_write(A_C001, 8'd0, 1'b0); void'(sb_q.pop_front());
    bus_write(A_E001, 8'd0, 1'b0);
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v || dut.reload_q !== e.rl_v)
      $display("[TB] FAIL basic_setup: got irq=%0b cnt=%0d reload=%0b, want irq=%0b cnt=%0d reload=%0b",
               irq, dut.counter_q, dut.reload_q, e.irq_v, e.cnt_v, e.rl_v);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      m2_cycles(3);
      a12_set(1'b1);
      if (k == 3) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) $display("[TB] FAIL basic_irq_early: got irq=%0b 3 clk after rise, want 0", irq);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
      end else begin
        settle();
      end
      e = sb_q.pop_front();
      n_checks++;
      if (irq !== e.irq_v || dut.counter_q !== e.cnt_v)
        $display("[TB] FAIL basic_rise%0d: got irq=%0b cnt=%0d, want irq=%0b cnt=%0d",
                 k, irq, dut.counter_q, e.irq_v, e.cnt_v);
      else n_pass++;
      a12_set(1'b0);
      settle();
      void'(sb_q.pop_front());
    end
    bus_write(A_E000, 8'd0, 1'b0);
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v)
      $display("[TB] FAIL basic_e000_clear: got irq=%0b cnt=%0d, want irq=%0b cnt=%0d",
               irq, dut.counter_q, e.irq_v, e.cnt_v);
    else n_pass++;
  endtask

  task automatic test_filter();
    exp_t e;
    int falls[4] = '{1, 2, 1, 2};
    for (int k = 0; k < 4; k++) begin
      m2_cycles(falls[k]);
      a12_set(1'b1);
      settle();
      e = sb_q.pop_front();
      n_checks++;
      if (irq !== e.irq_v || dut.counter_q !== e.cnt_v || dut.reload_q !== e.rl_v)
        $display("[TB] FAIL filter_rise%0d: got irq=%0b cnt=%0d reload=%0b, want irq=%0b cnt=%0d reload=%0b",
                 k, irq, dut.counter_q, dut.reload_q, e.irq_v, e.cnt_v, e.rl_v);
      else n_pass++;
      a12_set(1'b0);
      settle();
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_acclaim();
    exp_t e;
    do_reset(1'b1);
    bus_write(A_C000, 8'd1, 1'b0); void'(sb_q.pop_front());
    bus_write(A_C001, 8'd0, 1'b0); void'(sb_q.pop_front());
    bus_write(A_E001, 8'd0, 1'b0); void'(sb_q.pop_front());
    for (int k = 0; k < 32; k++) begin
      a12_set((k % 2) == 0);
      settle();
      e = sb_q.pop_front();
      if (k % 2 == 1 || k == 0) begin
        n_checks++;
        if (irq !== e.irq_v || dut.counter_q !== e.cnt_v || dut.reload_q !== e.rl_v)
          $display("[TB] FAIL acclaim_edge%0d: got irq=%0b cnt=%0d reload=%0b, want irq=%0b cnt=%0d reload=%0b",
                   k, irq, dut.counter_q, dut.reload_q, e.irq_v, e.cnt_v, e.rl_v);
        else n_pass++;
      end
    end
    bus_write(A_E000, 8'd0, 1'b0); void'(sb_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      a12_set((k % 2) == 0);
      settle();
      void'(sb_q.pop_front());
    end
    bus_write(A_C001, 8'd0, 1'b0); void'(sb_q.pop_front());
    for (int k = 0; k < 16; k++) begin
      a12_set((k % 2) == 0);
      settle();
      e = sb_q.pop_front();
      if (k % 2 == 1) begin
        n_checks++;
        if (irq !== e.irq_v || dut.counter_q !== e.cnt_v || dut.reload_q !== e.rl_v)
          $display("[TB] FAIL acclaim_restart%0d: got irq=%0b cnt=%0d reload=%0b, want irq=%0b cnt=%0d reload=%0b",
                   k, irq, dut.counter_q, dut.reload_q, e.irq_v, e.cnt_v, e.rl_v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [3:0] coinc_addr[4] = '{A_C001, A_E000, A_C000, A_E001};
    logic [7:0] coinc_data[4] = '{8'd0, 8'd0, 8'd9, 8'd0};
    do_reset(1'b0);
    bus_write(A_C000, 8'd5, 1'b0); void'(sb_q.pop_front());
    bus_write(A_C001, 8'd0, 1'b0); void'(sb_q.pop_front());
    bus_write(A_E001, 8'd0, 1'b0); void'(sb_q.pop_front());
    a12_set(1'b1); settle(); void'(sb_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      a12_set(1'b0); settle(); void'(sb_q.pop_front());
      if (k == 1) begin
        bus_write(A_C000, 8'd1, 1'b0); void'(sb_q.pop_front());
        m2_cycles(3);
        a12_set(1'b1); settle(); void'(sb_q.pop_front());
        a12_set(1'b0); settle(); void'(sb_q.pop_front());
      end
      m2_cycles(3);
      bus_write(coinc_addr[k], coinc_data[k], 1'b1);
      settle();
      e = sb_q.pop_front();
      n_checks++;
      if (irq !== e.irq_v || dut.counter_q !== e.cnt_v || dut.reload_q !== e.rl_v)
        $display("[TB] FAIL coincident%0d: got irq=%0b cnt=%0d reload=%0b, want irq=%0b cnt=%0d reload=%0b",
                 k, irq, dut.counter_q, dut.reload_q, e.irq_v, e.cnt_v, e.rl_v);
      else n_pass++;
    end
    a12_set(1'b0); settle(); void'(sb_q.pop_front());
    m2_cycles(3);
    a12_set(1'b1); settle();
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v)
      $display("[TB] FAIL new_latch_applies: got irq=%0b cnt=%0d, want irq=%0b cnt=%0d",
               irq, dut.counter_q, e.irq_v, e.cnt_v);
    else n_pass++;
  endtask

  task automatic test_latch_zero();
    exp_t e;
    logic [3:0] seq_addr[3] = '{A_E001, A_E000, A_E001};
    do_reset(1'b0);
    bus_write(A_C000, 8'd0, 1'b0); void'(sb_q.pop_front());
    bus_write(A_C001, 8'd0, 1'b0); void'(sb_q.pop_front());
    bus_write(A_E001, 8'd0, 1'b0); void'(sb_q.pop_front());
    m2_cycles(3);
    a12_set(1'b1); settle();
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v)
      $display("[TB] FAIL latch0_first: got irq=%0b cnt=%0d, want irq=%0b cnt=%0d",
               irq, dut.counter_q, e.irq_v, e.cnt_v);
    else n_pass++;
    a12_set(1'b0); settle(); void'(sb_q.pop_front());
    for (int k = 0; k < 3; k++) begin
      bus_write(seq_addr[k], 8'd0, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if (irq !== e.irq_v)
        $display("[TB] FAIL latch0_write%0d: got irq=%0b, want irq=%0b", k, irq, e.irq_v);
      else n_pass++;
    end
    m2_cycles(3);
    a12_set(1'b1); settle();
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v)
      $display("[TB] FAIL latch0_second: got irq=%0b cnt=%0d, want irq=%0b cnt=%0d",
               irq, dut.counter_q, e.irq_v, e.cnt_v);
    else n_pass++;
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    do_reset(1'b0);
    bus_write(A_C001, 8'd0, 1'b0); void'(sb_q.pop_front());
    bus_write(A_E001, 8'd0, 1'b0); void'(sb_q.pop_front());
    m2_cycles(1);
    a12_set(1'b1); settle(); void'(sb_q.pop_front());
    a12_set(1'b0); settle(); void'(sb_q.pop_front());
    bus_write(A_C000, 8'd5, 1'b0); void'(sb_q.pop_front());
    m2_cycles(2);
    a12_set(1'b1); settle();
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v)
      $display("[TB] FAIL pre_reset_state: got irq=%0b cnt=%0d, want irq=%0b cnt=%0d",
               irq, dut.counter_q, e.irq_v, e.cnt_v);
    else n_pass++;
    @(posedge clk);
    #3 map_rst = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0 || dut.counter_q !== 8'd0 || dut.reload_q !== 1'b0)
      $display("[TB] FAIL async_reset: got irq=%0b cnt=%0d reload=%0b, want all 0",
               irq, dut.counter_q, dut.reload_q);
    else n_pass++;
    model_reset();
    tick(2);
    map_rst = 1'b0;
    model_a12_rise();
    push_expect();
    settle();
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v || dut.low_cnt_q !== 2'd0)
      $display("[TB] FAIL post_reset_rise: got irq=%0b cnt=%0d low=%0d, want irq=%0b cnt=%0d low=0",
               irq, dut.counter_q, dut.low_cnt_q, e.irq_v, e.cnt_v);
    else n_pass++;
    bus_write(A_C000, 8'd7, 1'b0); void'(sb_q.pop_front());
    bus_write(A_E001, 8'd0, 1'b0); void'(sb_q.pop_front());
    a12_set(1'b0); settle(); void'(sb_q.pop_front());
    m2_cycles(3);
    a12_set(1'b1); settle();
    e = sb_q.pop_front();
    n_checks++;
    if (irq !== e.irq_v || dut.counter_q !== e.cnt_v)
      $display("[TB] FAIL post_reset_count: got irq=%0b cnt=%0d, want irq=%0b cnt=%0d",
               irq, dut.counter_q, e.irq_v, e.cnt_v);
    else n_pass++;
  endtask

  initial begin
    m_a12 = 1'b0;
    model_reset();
    test_reset();
    test_basic_count();
    test_filter();
    test_acclaim();
    test_simultaneous();
    test_latch_zero();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
